// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receiver and transmitter.
//   UART_OVERSAMPLE - default baud_tick strobes per bit period
//   UART_DATA_BITS  - default data bits per frame
//   rx_state_t      - receiver FSM states
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset; both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output, 2 clk latency
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Recovers start + DATA_BITS (+ even parity) + stop frames from rx
// using the OVERSAMPLE x baud strobe, and offers each byte on a valid/ready handshake.
// Optional feature macro: UART_RX_PARITY_EN (adds a PARITY state and the parity_err port).
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   baud_tick  - one-cycle strobe at OVERSAMPLE x baud
//   rx         - asynchronous serial line, idle high
//   data       - received byte, valid while valid=1
//   valid      - byte available, held until accepted
//   ready      - host accepts data when valid && ready
//   frame_err  - stop bit sampled 0 for the current data
//   parity_err - even parity mismatch for the current data (UART_RX_PARITY_EN only)
//   overrun    - one-cycle pulse: a frame completed while the slot was occupied
//   busy       - FSM not in IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_fail_q, par_fail_d;
    logic                 parity_err_q, parity_err_d;
`endif

    logic accept;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    assign accept = valid_q & ready;

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_fail_d   = par_fail_q;
        parity_err_d = parity_err_q;
`endif

        if (accept) begin
            valid_d     = 1'b0;
            frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                if (baud_tick && !rx_s) begin
                    state_d    = START;
                    tick_cnt_d = 4'd0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt_q == MID_CNT) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = 4'd0;
                            bit_idx_d  = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_q == LAST_CNT) begin
                        // LSB arrives first, so shift right from the MSB end.
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_d  = bit_idx_q + 3'd1;
                        tick_cnt_d = 4'd0;
                        if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt_q == LAST_CNT) begin
                        // Even parity: data ones plus parity bit must be even.
                        par_fail_d = (^shift_q) ^ rx_s;
                        tick_cnt_d = 4'd0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        // A same-cycle accept frees the slot for the new byte.
                        if (!valid_q || accept) begin
                            data_d      = shift_q;
                            valid_d     = 1'b1;
                            frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = par_fail_q;
`endif
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_fail_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_fail_q   <= par_fail_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
